// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - next-PC source encoding shared by pc_gen and the decode logic
package pc_pkg;

  localparam int SEL_W = 3;

  // Codes 6 and 7 are unused and fall back to sequential fetch.
  typedef enum logic [SEL_W-1:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_TRAP   = 3'd5
  } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with sticky overflow/underflow flags
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] top_idx;
  logic [AW:0]   count;

  assign top_idx = wptr - PTR_ONE;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  // Entry storage is deliberately left unreset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  // A push while full advances wptr onto the oldest slot, evicting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      wptr <= wptr + PTR_ONE;
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_ONE;
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wptr  <= wptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with six next-PC sources and a return-address stack
module pc_gen
  import pc_pkg::*;
#(
  parameter int           W         = 32,
  parameter logic [W-1:0] STEP      = 4,
  parameter logic [W-1:0] RESET_PC  = '0,
  parameter int           RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [W-1:0]     target,
  input  logic [W-1:0]     offset,
  input  logic [W-1:0]     trap_vec,
  output logic [W-1:0]     pc,
  output logic [W-1:0]     pc_next,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  logic [W-1:0] seq_pc;
  logic [W-1:0] ras_top;
  logic         ras_push;
  logic         ras_pop;

  assign seq_pc = pc + STEP;

  // RET on an empty stack still requests a pop so the stack can flag underflow.
  always_comb begin
    pc_next  = seq_pc;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (sel)
      PC_BRANCH: pc_next = pc + offset;
      PC_JUMP:   pc_next = target;
      PC_CALL: begin
        pc_next  = target;
        ras_push = en;
      end
      PC_RET: begin
        if (!ras_empty) begin
          pc_next = ras_top;
        end
        ras_pop = en;
      end
      PC_TRAP:   pc_next = trap_vec;
      default:   pc_next = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (en) begin
      pc <= pc_next;
    end
  end

  ras_stack #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (seq_pc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;
  import pc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  sel;
  logic [31:0] target;
  logic [31:0] offset;
  logic [31:0] trap_vec;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int errors = 0;
  int checks = 0;

  pc_gen #(
    .W         (32),
    .STEP      (32'd4),
    .RESET_PC  (32'h100),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel       (sel),
    .target    (target),
    .offset    (offset),
    .trap_vec  (trap_vec),
    .pc        (pc),
    .pc_next   (pc_next),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample 1 time unit past the rising edge.
  task automatic step(input logic e, input logic [2:0] s, input logic [31:0] t,
                      input logic [31:0] o, input logic [31:0] tv);
    @(negedge clk);
    en       = e;
    sel      = s;
    target   = t;
    offset   = o;
    trap_vec = tv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 3'd0; target = '0; offset = '0; trap_vec = '0;
    #12;
    check("reset_pc", pc, 32'h100);
    check("reset_empty", {31'd0, ras_empty}, 32'd1);
    check("reset_full", {31'd0, ras_full}, 32'd0);
    check("reset_ovf", {31'd0, ras_ovf}, 32'd0);
    check("reset_unf", {31'd0, ras_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, PC_SEQ, 0, 0, 0);  check("seq1", pc, 32'h104);
    step(1, PC_SEQ, 0, 0, 0);  check("seq2", pc, 32'h108);
    step(1, PC_SEQ, 0, 0, 0);  check("seq3", pc, 32'h10C);
    step(1, 3'd7, 0, 0, 0);    check("sel7_seq", pc, 32'h110);
    step(1, 3'd6, 0, 0, 0);    check("sel6_seq", pc, 32'h114);

    step(1, PC_JUMP, 32'h200, 0, 0);           check("jump_200", pc, 32'h200);
    step(1, PC_BRANCH, 0, 32'hFFFF_FFF0, 0);   check("branch_back", pc, 32'h1F0);
    step(1, PC_JUMP, 32'h8000, 0, 0);          check("jump_8000", pc, 32'h8000);
    step(0, PC_JUMP, 32'h9000, 0, 0);
    check("stall_hold", pc, 32'h8000);
    check("stall_pc_next", pc_next, 32'h9000);

    step(1, PC_JUMP, 32'h40, 0, 0);    check("jump_40", pc, 32'h40);
    step(1, PC_CALL, 32'h1000, 0, 0);  check("call1", pc, 32'h1000);
    step(1, PC_SEQ, 0, 0, 0);          check("seq_1004", pc, 32'h1004);
    step(1, PC_CALL, 32'h2000, 0, 0);  check("call2", pc, 32'h2000);
    step(1, PC_RET, 0, 0, 0);          check("ret1", pc, 32'h1008);
    step(1, PC_RET, 0, 0, 0);          check("ret2", pc, 32'h44);
    check("nest_empty", {31'd0, ras_empty}, 32'd1);
    check("nest_unf", {31'd0, ras_unf}, 32'd0);

    // Five calls into a four-entry stack: 0x304 is evicted.
    step(1, PC_JUMP, 32'h300, 0, 0);
    step(1, PC_CALL, 32'h400, 0, 0);
    step(1, PC_CALL, 32'h500, 0, 0);
    step(1, PC_CALL, 32'h600, 0, 0);
    step(1, PC_CALL, 32'h700, 0, 0);
    check("full_at4", {31'd0, ras_full}, 32'd1);
    check("no_ovf_at4", {31'd0, ras_ovf}, 32'd0);
    step(1, PC_CALL, 32'h800, 0, 0);
    check("call5_pc", pc, 32'h800);
    check("ovf_set", {31'd0, ras_ovf}, 32'd1);
    check("full_after_ovf", {31'd0, ras_full}, 32'd1);
    step(1, PC_RET, 0, 0, 0);  check("oret1", pc, 32'h704);
    step(1, PC_RET, 0, 0, 0);  check("oret2", pc, 32'h604);
    step(1, PC_RET, 0, 0, 0);  check("oret3", pc, 32'h504);
    step(1, PC_RET, 0, 0, 0);  check("oret4", pc, 32'h404);
    check("oret_empty", {31'd0, ras_empty}, 32'd1);
    check("oret_no_unf", {31'd0, ras_unf}, 32'd0);
    step(1, PC_RET, 0, 0, 0);  check("oret5_seq", pc, 32'h408);
    check("unf_set", {31'd0, ras_unf}, 32'd1);
    check("ovf_sticky", {31'd0, ras_ovf}, 32'd1);

    step(1, PC_JUMP, 32'hFFFF_FFFC, 0, 0);  check("jump_top", pc, 32'hFFFF_FFFC);
    step(1, PC_SEQ, 0, 0, 0);               check("wrap_zero", pc, 32'h0);
    step(1, PC_CALL, 32'h500, 0, 0);        check("call_pre_trap", pc, 32'h500);
    step(1, PC_TRAP, 0, 0, 32'h80);         check("trap_pc", pc, 32'h80);
    check("trap_not_empty", {31'd0, ras_empty}, 32'd0);
    step(1, PC_RET, 0, 0, 0);               check("ret_after_trap", pc, 32'h4);
    check("trap_one_entry", {31'd0, ras_empty}, 32'd1);

    step(1, PC_CALL, 32'h600, 0, 0);        check("call_pre_reset", pc, 32'h600);
    @(negedge clk);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pc", pc, 32'h100);
    check("async_reset_empty", {31'd0, ras_empty}, 32'd1);
    check("async_reset_ovf", {31'd0, ras_ovf}, 32'd0);
    check("async_reset_unf", {31'd0, ras_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, PC_RET, 0, 0, 0);               check("post_reset_ret", pc, 32'h104);
    check("post_reset_unf", {31'd0, ras_unf}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the CPU fetch stage. It holds the architectural PC and selects the next PC from six sources: sequential, PC-relative branch, absolute jump, call, return and trap. Call/return use an internal circular return-address stack (RAS). It sits between the decode/branch-resolution logic, which drives the selector and operands, and instruction memory, which consumes `pc`.

## Interface
- `W`, 32, PC/address width in bits.
- `STEP`, 4, sequential increment in bytes.
- `RESET_PC`, 0, PC value loaded on reset.
- `RAS_DEPTH`, 4, return-address stack entries; power of two, ≥2.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  update enable; 0 = stall: PC, RAS and flags hold.
- `sel`  in  3  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5 TRAP; 6 and 7 behave as SEQ.
- `target`  in  W  absolute target for JUMP/CALL.
- `offset`  in  W  two's-complement offset for BRANCH.
- `trap_vec`  in  W  trap handler address.
- `pc`  out  W  current PC (registered).
- `pc_next`  out  W  value `pc` takes at the next enabled edge (combinational).
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.
- `ras_ovf`  out  1  sticky: a push occurred while full.
- `ras_unf`  out  1  sticky: a pop occurred while empty.

## Operation
- SEQ: `pc_next = pc + STEP`.
- BRANCH: `pc_next = pc + offset`.
- JUMP: `pc_next = target`.
- CALL: `pc_next = target`; push `pc + STEP` onto the RAS.
- RET, RAS non-empty: `pc_next` = top entry; pop.
- RET, RAS empty: `pc_next = pc + STEP`; no pop; set `ras_unf`.
- TRAP: `pc_next = trap_vec`; RAS untouched.
- All arithmetic is unsigned modulo 2^W; wrap-around is silent (`pc = 2^W − STEP`, SEQ → 0).
- RAS is circular (write pointer plus count).
  - Push when full overwrites the oldest entry, keeps count = RAS_DEPTH, and sets `ras_ovf`.
  - Subsequent pops return entries newest-first. After RAS_DEPTH pops the stack is empty; the overwritten entry is lost.
- `ras_ovf` and `ras_unf` clear only on reset.
- `en` = 0: no state changes; `pc_next` still reflects the current inputs.

## Timing
- Reset asserted, asynchronous: `pc = RESET_PC`, RAS count = 0, `ras_empty = 1`, `ras_full = 0`, `ras_ovf = ras_unf = 0`. The RAS data array is not reset.
- Reset released mid-operation: the first enabled edge after release uses SEQ semantics from RESET_PC as normal; no pending state survives reset.
- Inputs are sampled at the rising edge when `en` = 1. `pc` updates on that same edge, so a redirect has 1-cycle latency and no bubble is inserted by this block.
- `pc_next` is valid in the same cycle as `sel`/operands; it is combinational from `pc`, RAS top, `sel`, `target`, `offset` and `trap_vec`.
- `ras_empty`/`ras_full` are derived from the registered count and change the cycle after a push or pop.
- Back-to-back CALL/RET on consecutive enabled cycles is legal. RET immediately after CALL returns the just-pushed address.

## Structure
- Package `pc_pkg`: the `sel` encoding constants (`PC_SEQ` … `PC_TRAP`) and a `pc_sel_t` typedef. Decode logic imports the same package.
- Sub-module `ras_stack`: parameters `W`, `DEPTH`; ports `push`, `pop`, `din`, `top`, `empty`, `full`, `ovf`, `unf`.
- `pc_gen` contains the next-PC mux, the adder and the PC register.

## Test plan
- Reset, then 3 SEQ cycles with W=32, RESET_PC=0x100 → `pc` = 0x100, 0x104, 0x108, 0x10C.
- `pc`=0x200, BRANCH with offset=0xFFFFFFF0 → 0x1F0; JUMP target=0x8000 → 0x8000; `en`=0 with sel=JUMP → `pc` holds.
- CALL 0x1000 from 0x40, CALL 0x2000 from 0x1004, RET, RET → `pc` = 0x1000, 0x2000, 0x1008, 0x44; then `ras_empty` = 1.
- RAS_DEPTH=4: 5 CALLs, then 5 RETs → `ras_ovf` = 1; first 4 RETs return the last 4 pushes newest-first; 5th RET gives `pc + 4` and sets `ras_unf` = 1.
- `pc` = 0xFFFFFFFC, SEQ → 0x00000000; TRAP trap_vec=0x80 during a non-empty RAS → `pc` = 0x80, RAS count unchanged.
- Assert `rst_n` between a CALL and its RET → `pc` = RESET_PC immediately (no clock edge), `ras_empty` = 1, flags 0; the following RET sets `ras_unf`.
